// File: rtl/lc3b_fetch_unit.sv
// lc3b_fetch_unit: PC generator, single-outstanding memory read handshake and
// first-word-fall-through instruction queue; redirects flush and restart fetch.
module lc3b_fetch_unit #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    output logic                       mem_read,
    output logic [WIDTH-1:0]           mem_address,
    input  logic [WIDTH-1:0]           mem_rdata,
    input  logic                       mem_resp,
    output logic                       inst_valid,
    output logic [WIDTH-1:0]           inst,
    output logic [WIDTH-1:0]           inst_pc,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_disc_addr;
    logic [WIDTH-1:0] r_inst_q [DEPTH];
    logic [WIDTH-1:0] r_pc_q   [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push      = (r_state == REQ) && mem_resp && !redirect;
    assign w_pop       = inst_ready && (r_count != '0);
    assign mem_read    = (r_state != IDLE);
    assign mem_address = (r_state == DISCARD) ? r_disc_addr : r_fetch_pc;
    assign inst_valid  = (r_count != '0);
    assign inst        = r_inst_q[r_rd_ptr];
    assign inst_pc     = r_pc_q[r_rd_ptr];
    assign count       = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_disc_addr <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect)
                        r_fetch_pc <= redirect_pc;
                    else if (r_count < FULL)
                        r_state <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        // keep the abandoned address on the bus until memory answers
                        r_fetch_pc  <= redirect_pc;
                        r_disc_addr <= r_fetch_pc;
                        r_state     <= mem_resp ? IDLE : DISCARD;
                    end else if (mem_resp) begin
                        r_fetch_pc <= r_fetch_pc + WIDTH'(2);
                        r_state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect)
                        r_fetch_pc <= redirect_pc;
                    if (mem_resp)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_q[r_wr_ptr] <= mem_rdata;
            r_pc_q[r_wr_ptr]   <= r_fetch_pc;
        end
    end
endmodule

// File: doc/lc3b_fetch_unit.md
Name: lc3b_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation LC-3b core. It replaces the single PC/MAR/MDR/IR fetch path with a PC generator, a memory read handshake and a DEPTH-entry first-word-fall-through instruction queue, so fetch runs ahead of decode. It sits between the instruction memory port and the decode/control stage. Branches and jumps redirect it, and a redirect flushes all queued instructions.

Parameters:
WIDTH, 16, word and address width in bits
DEPTH, 4, queue entries; must be a power of 2 and at least 2
RESET_PC, 16'h0000, fetch address after reset; WIDTH bits wide

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
redirect  in  1  branch/jump taken; flush the queue and restart fetch
redirect_pc  in  WIDTH  new fetch address, sampled when redirect=1
mem_read  out  1  instruction memory read request
mem_address  out  WIDTH  read address; stable while mem_read=1
mem_rdata  in  WIDTH  read data; valid when mem_resp=1
mem_resp  in  1  single-cycle read completion
inst_valid  out  1  queue head holds a valid instruction
inst  out  WIDTH  instruction at the queue head
inst_pc  out  WIDTH  address of the queue-head instruction
inst_ready  in  1  consumer pops the head when inst_valid=1 and inst_ready=1
count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (asynchronous, any cycle, including mid-request):
  - state=IDLE, fetch_pc=RESET_PC, count=0, queue pointers=0.
  - mem_read=0, inst_valid=0.
  - Any in-flight memory response is forgotten.
- States: IDLE, REQ, DISCARD.
  - mem_read = (state==REQ || state==DISCARD).
  - mem_address = fetch_pc in REQ. In DISCARD it is the latched address of the abandoned request.
- IDLE -> REQ when count < DEPTH and redirect=0.
  - First mem_read is the first cycle after the first clock edge following reset release.
- REQ, mem_resp=1, redirect=0:
  - Push {fetch_pc, mem_rdata} into the queue.
  - fetch_pc <= fetch_pc + 2 (wraps modulo 2^WIDTH).
  - Go to IDLE. mem_read drops for at least 1 cycle between requests.
- REQ, redirect=1, mem_resp=0:
  - Flush the queue (count=0).
  - fetch_pc <= redirect_pc.
  - Go to DISCARD. The old address stays on mem_address.
- REQ, redirect=1, mem_resp=1:
  - Drop the response and flush.
  - fetch_pc <= redirect_pc.
  - Go to IDLE.
- DISCARD:
  - Hold mem_read and the old address until mem_resp. Drop that data, then go to IDLE.
  - A further redirect while in DISCARD overwrites fetch_pc and flushes again; state stays DISCARD.
- IDLE, redirect=1: flush, fetch_pc <= redirect_pc, stay IDLE for that cycle.
- Queue:
  - First-word-fall-through; inst and inst_pc come combinationally from the head entry.
  - inst_valid = (count != 0).
  - Push and pop in the same cycle leave count unchanged.
  - Pop on empty is ignored.
  - A request is only issued when count < DEPTH, and at most one is outstanding, so a push never overflows.
- Redirect has priority over both pop and push in the same cycle: the queue becomes empty next cycle.
- While inst_valid=1 and inst_ready=0, inst and inst_pc hold stable.
- Best-case throughput is 1 instruction per (memory latency + 1) cycles.

Test Plan:
- Reset release, RESET_PC=0, memory responds 1 cycle after mem_read with data 16'h1000+addr, inst_ready=1 -> mem_address sequence 0x0000, 0x0002, 0x0004; inst/inst_pc pairs (0x1000,0x0000), (0x1002,0x0002), … in order.
- inst_ready=0, DEPTH=4 -> exactly 4 requests complete, count=4, mem_read stays 0. One pop -> count=3 and the next request issues to address 0x0008.
- redirect=1 with redirect_pc=0x3000 while a request to 0x0006 is pending (mem_resp 3 cycles later) -> count=0 next cycle; mem_address holds 0x0006 until resp; that data is never visible. Next request is to 0x3000, first inst_pc=0x3000.
- redirect and mem_resp in the same cycle, plus a pop -> response dropped, count=0, the following request goes to redirect_pc.
- fetch_pc=0xFFFE, WIDTH=16 -> after the push, next mem_address=0x0000.
- reset_n asserted mid-REQ with mem_read=1 -> mem_read=0 and inst_valid=0 immediately (asynchronously). After release, fetch restarts at RESET_PC; a late mem_resp from the old request during IDLE is ignored.
